// File: rtl/multi_queue_spill_buffer.sv
// NUM_Q circular queues with round-robin spill/fill burst arbitration toward a buffer manager.
// Optional sticky protocol-error flag and spill-stall watchdog: define MQSB_ERR_CHECK_EN.
module multi_queue_spill_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_Q           = 4,
    parameter int DEPTH           = 256,
    parameter int SPILL_THRESHOLD = 224,
    parameter int FILL_THRESHOLD  = 32,
    parameter int SPILL_BURST     = 64,
    parameter int FILL_BURST      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(NUM_Q)-1:0] wr_ch,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(NUM_Q)-1:0] rd_ch,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_Q-1:0]         full,
    output logic [NUM_Q-1:0]         empty,
    output logic                     spill_req,
    output logic                     fill_req,
    output logic [$clog2(NUM_Q)-1:0] req_ch,
    input  logic                     spill_grant,
    input  logic                     fill_grant,
    output logic [DATA_WIDTH-1:0]    spill_data,
    output logic                     spill_data_valid,
    input  logic                     spill_data_ready,
    input  logic [DATA_WIDTH-1:0]    fill_data,
    input  logic                     fill_data_valid,
    output logic                     fill_data_ready,
    input  logic                     fill_last,
    output logic                     err
);
    localparam int QW   = $clog2(NUM_Q);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int MAXB = (SPILL_BURST > FILL_BURST) ? SPILL_BURST : FILL_BURST;
    localparam int BW   = $clog2(MAXB) + 1;

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t          state_reg, state_next;
    logic [QW-1:0]   arb_ptr_reg, req_ch_reg, sel_ch, idx;
    logic [BW-1:0]   burst_cnt_reg;
    logic            run_reg, sel_spill, sel_fill, burst_done;
    logic            spill_fire, fill_fire;
    logic [PW-1:0]   count [NUM_Q];
    logic [PW-1:0]   nxt_count [NUM_Q];
    logic [DATA_WIDTH-1:0] head_word [NUM_Q];
    logic [DATA_WIDTH-1:0] tail_word [NUM_Q];
    logic [NUM_Q-1:0] wr_acc_q, rd_acc_q;

    // Each queue owns its storage so a normal write and a fill write to different queues never collide.
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_q
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, count_reg, count_next;
        logic [AW-1:0] tail_addr;
        logic          push, pop_tail;

        assign full[gi]     = (count_reg == PW'(DEPTH));
        assign empty[gi]    = (count_reg == '0);
        assign wr_acc_q[gi] = wr_en && (wr_ch == QW'(gi)) && !full[gi];
        assign rd_acc_q[gi] = rd_en && (rd_ch == QW'(gi)) && !empty[gi];
        assign push         = wr_acc_q[gi] || (fill_fire && (req_ch_reg == QW'(gi)));
        assign pop_tail     = spill_fire && (req_ch_reg == QW'(gi));
        assign tail_addr    = wr_ptr_reg[AW-1:0] - AW'(1);
        assign head_word[gi] = mem[rd_ptr_reg[AW-1:0]];
        assign tail_word[gi] = mem[tail_addr];
        assign count_next   = count_reg + PW'(push) - PW'(pop_tail) - PW'(rd_acc_q[gi]);
        assign count[gi]     = count_reg;
        assign nxt_count[gi] = count_next;

        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr_reg[AW-1:0]] <= wr_acc_q[gi] ? wr_data : fill_data;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                else if (pop_tail)
                    wr_ptr_reg <= wr_ptr_reg - PW'(1);
                if (rd_acc_q[gi])
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                count_reg <= count_next;
            end
        end
    end

    assign rd_data = head_word[rd_ch];

    // Round-robin scan from arb_ptr; any spill candidate outranks every fill candidate.
    always_comb begin
        sel_ch    = arb_ptr_reg;
        sel_spill = 1'b0;
        sel_fill  = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            idx = arb_ptr_reg + QW'(i);
            if (!sel_spill && (count[idx] >= PW'(SPILL_THRESHOLD))) begin
                sel_spill = 1'b1;
                sel_ch    = idx;
            end
        end
        for (int i = 0; i < NUM_Q; i++) begin
            idx = arb_ptr_reg + QW'(i);
            if (!sel_spill && !sel_fill && (count[idx] <= PW'(FILL_THRESHOLD))) begin
                sel_fill = 1'b1;
                sel_ch   = idx;
            end
        end
    end

    assign spill_req = run_reg && (state_reg == IDLE) && sel_spill;
    assign fill_req  = run_reg && (state_reg == IDLE) && sel_fill;
    assign req_ch    = (state_reg == IDLE) ? sel_ch : req_ch_reg;

    assign spill_data       = tail_word[req_ch_reg];
    assign spill_data_valid = (state_reg == SPILL) && (count[req_ch_reg] != '0) &&
                              !wr_acc_q[req_ch_reg] &&
                              !((count[req_ch_reg] == PW'(1)) && rd_acc_q[req_ch_reg]);
    assign fill_data_ready  = (state_reg == FILL) && !full[req_ch_reg] && !wr_acc_q[req_ch_reg];
    assign spill_fire       = spill_data_valid && spill_data_ready;
    assign fill_fire        = fill_data_valid && fill_data_ready;

    always_comb begin
        state_next = state_reg;
        burst_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (spill_grant && spill_req)
                    state_next = SPILL;
                else if (fill_grant && fill_req)
                    state_next = FILL;
            end
            SPILL: begin
                if ((spill_fire && (burst_cnt_reg + BW'(1) == BW'(SPILL_BURST))) ||
                    (nxt_count[req_ch_reg] == '0)) begin
                    state_next = IDLE;
                    burst_done = 1'b1;
                end
            end
            FILL: begin
                if (fill_fire && ((burst_cnt_reg + BW'(1) == BW'(FILL_BURST)) || fill_last)) begin
                    state_next = IDLE;
                    burst_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            arb_ptr_reg   <= '0;
            req_ch_reg    <= '0;
            burst_cnt_reg <= '0;
            run_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            if (state_reg == IDLE) begin
                burst_cnt_reg <= '0;
                if (state_next != IDLE)
                    req_ch_reg <= sel_ch;
            end else if (spill_fire || fill_fire) begin
                burst_cnt_reg <= burst_cnt_reg + BW'(1);
            end
            if (burst_done)
                arb_ptr_reg <= req_ch_reg + QW'(1);
        end
    end

`ifdef MQSB_ERR_CHECK_EN
    logic [7:0] wd_reg;
    logic       err_reg;
    logic       spill_stall;

    // A spill with data held back only by a colliding normal access counts toward the watchdog.
    assign spill_stall = (state_reg == SPILL) && (count[req_ch_reg] != '0) && !spill_data_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            if (!spill_stall)
                wd_reg <= '0;
            else if (wd_reg != 8'hFF)
                wd_reg <= wd_reg + 8'd1;
            if ((wr_en && full[wr_ch]) || (rd_en && empty[rd_ch]) ||
                (spill_stall && (wd_reg == 8'hFF)))
                err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_multi_queue_spill_buffer.sv
// Scoreboard bench: stimulus queues expected read/spill words, a negedge monitor compares them.
module tb_multi_queue_spill_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_ch = '0;
    logic [31:0] rd_data;
    logic [3:0]  full, empty;
    logic        spill_req, fill_req;
    logic [1:0]  req_ch;
    logic        spill_grant = 1'b0, fill_grant = 1'b0;
    logic [31:0] spill_data;
    logic        spill_data_valid;
    logic        spill_data_ready = 1'b0;
    logic [31:0] fill_data = '0;
    logic        fill_data_valid = 1'b0;
    logic        fill_data_ready;
    logic        fill_last = 1'b0;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rd[$];
    logic [31:0] exp_spill[$];

    always #5 clk = ~clk;

    multi_queue_spill_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data),
        .full(full), .empty(empty),
        .spill_req(spill_req), .fill_req(fill_req), .req_ch(req_ch),
        .spill_grant(spill_grant), .fill_grant(fill_grant),
        .spill_data(spill_data), .spill_data_valid(spill_data_valid), .spill_data_ready(spill_data_ready),
        .fill_data(fill_data), .fill_data_valid(fill_data_valid), .fill_data_ready(fill_data_ready),
        .fill_last(fill_last), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got %0d expected no transaction", name, act);
    endtask

    // Monitor: every accepted read and every spill beat consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en && !empty[rd_ch]) begin
                if (exp_rd.size() == 0) unexpected("rd_data", rd_data);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end
            if (spill_data_valid && spill_data_ready) begin
                if (exp_spill.size() == 0) unexpected("spill_data", spill_data);
                else chk("spill_data", spill_data, exp_spill.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [31:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [31:0] e);
        exp_rd.push_back(e);
        rd_en = 1'b1; rd_ch = ch;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_spill_req", 32'(spill_req), 0);
        chk("rst_fill_req", 32'(fill_req), 0);
        chk("rst_req_ch", 32'(req_ch), 0);
        chk("rst_spill_valid", 32'(spill_data_valid), 0);
        chk("rst_fill_ready", 32'(fill_data_ready), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Grant a spill with ready held high and count beats until valid drops.
    task automatic run_spill(input string name, input int exp_beats);
        int beats = 0;
        int guard = 0;
        spill_grant = 1'b1; spill_data_ready = 1'b1;
        tick();
        spill_grant = 1'b0;
        while (guard < 300) begin
            @(negedge clk);
            guard++;
            if (spill_data_valid) beats++;
            else if (beats > 0) break;
        end
        @(posedge clk); #1;
        spill_data_ready = 1'b0;
        chk(name, beats, exp_beats);
    endtask

    initial begin
        int guard;
        do_reset();
        chk("post_rst_fill_req", 32'(fill_req), 1);
        chk("post_rst_req_ch", 32'(req_ch), 0);

        // Plain FIFO order on q2.
        for (int i = 0; i < 10; i++) wr(2'd2, 32'(i));
        chk("q2_not_empty", 32'(empty), 32'hB);
        for (int i = 0; i < 10; i++) rd(2'd2, 32'(i));
        chk("q2_drained_empty", 32'(empty), 32'hF);

        // q1 reaches the spill threshold; spill pops from the tail.
        for (int i = 0; i < 223; i++) wr(2'd1, 32'(i));
        chk("q1_223_no_spill", 32'(spill_req), 0);
        wr(2'd1, 32'd223);
        chk("q1_spill_req", 32'(spill_req), 1);
        chk("q1_req_ch", 32'(req_ch), 1);
        for (int i = 223; i >= 160; i--) exp_spill.push_back(32'(i));
        run_spill("q1_spill_beats", 64);
        chk("q1_spill_req_clear", 32'(spill_req), 0);

        // Fill burst on q2 terminated early by fill_last.
        chk("q2_fill_req", 32'(fill_req), 1);
        chk("q2_fill_req_ch", 32'(req_ch), 2);
        fill_grant = 1'b1;
        tick();
        fill_grant = 1'b0;
        for (int j = 0; j < 5; j++) begin
            fill_data = 32'(700 + j); fill_data_valid = 1'b1; fill_last = (j == 4);
            @(negedge clk);
            chk("fill_ready_beat", 32'(fill_data_ready), 1);
            @(posedge clk); #1;
        end
        fill_data_valid = 1'b0; fill_last = 1'b0;
        @(negedge clk);
        chk("fill_exit_ready_low", 32'(fill_data_ready), 0);
        @(posedge clk); #1;
        for (int j = 0; j < 5; j++) rd(2'd2, 32'(700 + j));
        chk("q2_fill_count5_empty", 32'(empty[2]), 1);

        // Spill on q1 with three colliding normal writes mid-burst.
        for (int k = 0; k < 64; k++) wr(2'd1, 32'(3000 + k));
        chk("q1b_spill_req", 32'(spill_req), 1);
        chk("q1b_req_ch", 32'(req_ch), 1);
        exp_spill.push_back(32'd3063); exp_spill.push_back(32'd3062);
        exp_spill.push_back(32'd4002); exp_spill.push_back(32'd4001); exp_spill.push_back(32'd4000);
        for (int i = 3061; i >= 3003; i--) exp_spill.push_back(32'(i));
        spill_grant = 1'b1; spill_data_ready = 1'b1;
        tick();
        spill_grant = 1'b0;
        tick();
        tick();
        for (int j = 0; j < 3; j++) begin
            wr_en = 1'b1; wr_ch = 2'd1; wr_data = 32'(4000 + j);
            @(negedge clk);
            chk("spill_valid_collide", 32'(spill_data_valid), 0);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (spill_data_valid && guard < 200);
        if (guard >= 200) unexpected("spill_timeout", 32'(guard));
        @(posedge clk); #1;
        spill_data_ready = 1'b0;
        chk("collide_scoreboard_drained", 32'(exp_spill.size()), 0);
        for (int i = 0; i < 160; i++) rd(2'd1, 32'(i));
        for (int i = 0; i < 3; i++) rd(2'd1, 32'(3000 + i));
        chk("q1_final_empty", 32'(empty[1]), 1);

        // Read of an empty queue.
        rd_en = 1'b1; rd_ch = 2'd0;
        tick();
        rd_en = 1'b0;
        @(negedge clk);
`ifdef MQSB_ERR_CHECK_EN
        chk("err_set", 32'(err), 1);
        tick(); tick(); tick();
        chk("err_sticky", 32'(err), 1);
`else
        chk("err_tied_low", 32'(err), 0);
`endif
        chk("q0_still_empty", 32'(empty[0]), 1);

        // Round-robin fairness between q0 and q3 from a fresh arbiter pointer.
        do_reset();
        for (int i = 0; i < 224; i++) wr(2'd0, 32'(1000 + i));
        for (int i = 0; i < 224; i++) wr(2'd3, 32'(2000 + i));
        chk("rr_first_req_ch", 32'(req_ch), 0);
        chk("rr_first_spill_req", 32'(spill_req), 1);
        for (int i = 1223; i >= 1160; i--) exp_spill.push_back(32'(i));
        run_spill("rr_q0_beats", 64);
        for (int k = 0; k < 64; k++) wr(2'd0, 32'(1500 + k));
        chk("rr_second_req_ch", 32'(req_ch), 3);
        for (int i = 2223; i >= 2160; i--) exp_spill.push_back(32'(i));
        run_spill("rr_q3_beats", 64);
        chk("rr_third_req_ch", 32'(req_ch), 0);
        for (int i = 1563; i >= 1500; i--) exp_spill.push_back(32'(i));
        run_spill("rr_q0b_beats", 64);
        chk("rr_spill_req_clear", 32'(spill_req), 0);

        chk("rd_scoreboard_drained", 32'(exp_rd.size()), 0);
        chk("spill_scoreboard_drained", 32'(exp_spill.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
